// File: rtl/fila_serializer_pkg.sv
// rtl/fila_serializer_pkg.sv - shared state type and queue sizing for the byte serializer
package fila_serializer_pkg;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SHIFT, DONE} ser_state_t;

  localparam int QUEUE_DEPTH = 8;
  localparam int LEN_W       = 8;

endpackage

// File: rtl/fila_serializer_bit_timer.sv
// rtl/fila_serializer_bit_timer.sv - ready-gated per-bit hold counter, pulses bit_accept on the final cycle
module ser_bit_timer
  import fila_serializer_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk_10KHz,
  input  logic reset,
  input  logic clear,
  input  logic active,
  input  logic ready_in,
  output logic bit_accept
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_accept = active && ready_in && (cnt == LAST_CNT);

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (active && ready_in) begin
      cnt <= bit_accept ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fila_serializer.sv
// rtl/fila_serializer.sv - dequeues bytes from the queue and shifts them out serially; FILA_SERIALIZER_PARITY_EN appends an even-parity bit
module fila_serializer
  import fila_serializer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic              enable_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              dequeue_out,
  input  logic              ready_in,
  output logic              serial_out,
  output logic              bit_valid,
  output logic              byte_done,
  output logic              busy,
  output logic [7:0]        tx_count
);

`ifdef FILA_SERIALIZER_PARITY_EN
  localparam int SH_W = DATA_W + 1;
`else
  localparam int SH_W = DATA_W;
`endif
  localparam int IDX_W = (SH_W > 1) ? $clog2(SH_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SH_W - 1);

  ser_state_t        state, state_next;
  logic [DATA_W-1:0] ordered;
  logic [SH_W-1:0]   load_word, shreg, shifted;
  logic [IDX_W-1:0]  bit_idx;
  logic              bit_accept, last_bit;

  // Reorder once at capture so the transmit bit is always the top of shreg.
  always_comb begin
    ordered = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ordered[i] = (MSB_FIRST != 0) ? data_in[i] : data_in[DATA_W-1-i];
    end
  end

`ifdef FILA_SERIALIZER_PARITY_EN
  assign load_word = {ordered, ^data_in};
`else
  assign load_word = ordered;
`endif

  assign shifted  = shreg << 1;
  assign last_bit = (bit_idx == LAST_IDX);

  ser_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_bit_timer (
    .clk_10KHz  (clk_10KHz),
    .reset      (reset),
    .clear      (state == WAIT),
    .active     (state == SHIFT),
    .ready_in   (ready_in),
    .bit_accept (bit_accept)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable_in && (len_in != '0)) state_next = REQ;
      REQ:     state_next = WAIT;
      WAIT:    state_next = SHIFT;
      SHIFT:   if (bit_accept && last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Outputs are decoded from state_next so each one is a flop aligned with its state.
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      dequeue_out <= 1'b0;
      bit_valid   <= 1'b0;
      byte_done   <= 1'b0;
      busy        <= 1'b0;
      serial_out  <= 1'b0;
      tx_count    <= '0;
      shreg       <= '0;
      bit_idx     <= '0;
    end else begin
      dequeue_out <= (state_next == REQ);
      bit_valid   <= (state_next == SHIFT);
      byte_done   <= (state_next == DONE);
      busy        <= (state_next != IDLE);
      if (state_next == DONE) tx_count <= tx_count + 8'd1;

      if (state == WAIT) begin
        shreg      <= load_word;
        bit_idx    <= '0;
        serial_out <= load_word[SH_W-1];
      end else if (bit_accept && !last_bit) begin
        shreg      <= shifted;
        bit_idx    <= bit_idx + 1'b1;
        serial_out <= shifted[SH_W-1];
      end else if (state_next != SHIFT) begin
        serial_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fila_serializer.sv
// tb/tb_fila_serializer.sv - two serializer configurations checked cycle by cycle against a bit-stream model
`timescale 1ns/1ps
module tb_fila_serializer;

`ifdef FILA_SERIALIZER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk_10KHz = 1'b0;
  logic       reset = 1'b0;
  logic       enable_in = 1'b0;
  logic       ready_in = 1'b0;
  logic [7:0] len_q [2];
  logic [7:0] dat_q [2];
  logic [1:0] dq, so, bv, bd, bsy;
  logic [7:0] txc [2];

  always #5 clk_10KHz = ~clk_10KHz;

  fila_serializer #(.DATA_W(8), .BIT_CYCLES(1), .MSB_FIRST(1)) u_dut0 (
    .clk_10KHz(clk_10KHz), .reset(reset), .enable_in(enable_in),
    .len_in(len_q[0]), .data_in(dat_q[0]), .dequeue_out(dq[0]),
    .ready_in(ready_in), .serial_out(so[0]), .bit_valid(bv[0]),
    .byte_done(bd[0]), .busy(bsy[0]), .tx_count(txc[0]));

  fila_serializer #(.DATA_W(8), .BIT_CYCLES(3), .MSB_FIRST(0)) u_dut1 (
    .clk_10KHz(clk_10KHz), .reset(reset), .enable_in(enable_in),
    .len_in(len_q[1]), .data_in(dat_q[1]), .dequeue_out(dq[1]),
    .ready_in(ready_in), .serial_out(so[1]), .bit_valid(bv[1]),
    .byte_done(bd[1]), .busy(bsy[1]), .tx_count(txc[1]));

  typedef struct packed {logic dq; logic bv; logic ser; logic bd; logic bsy;} exp_t;

  exp_t       cur [2];
  bit         bits [2][$];
  logic [7:0] mq [2][$];
  logic [7:0] eq [2][$];
  logic [7:0] cap [2];
  int         tx [2];
  int         checks = 0, errors = 0, cyc = 0;
  logic [31:0] col0, col1;
  int         n0, n1;
  int         dq_times[$], bd_times[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expand a popped byte into the per-accept-cycle values the sink must see.
  task automatic load_bits(input int i, input logic [7:0] b);
    int bc;
    bit v;
    bc = (i == 0) ? 1 : 3;
    bits[i].delete();
    for (int j = 0; j < 8; j++) begin
      v = (i == 0) ? b[7-j] : b[j];
      repeat (bc) bits[i].push_back(v);
    end
`ifdef FILA_SERIALIZER_PARITY_EN
    repeat (bc) bits[i].push_back(^b);
`endif
  endtask

  task automatic model_step(input int i, input bit en, input bit rdy);
    exp_t n;
    n = '0;
    if (cur[i].bv) begin
      if (rdy) void'(bits[i].pop_front());
      if (bits[i].size() == 0) begin
        n.bd = 1; n.bsy = 1; tx[i] = (tx[i] + 1) % 256;
      end else begin
        n.bv = 1; n.ser = bits[i][0]; n.bsy = 1;
      end
    end else if (cur[i].dq) begin
      n.bsy = 1;
    end else if (cur[i].bsy && !cur[i].bd) begin
      load_bits(i, cap[i]);
      n.bv = 1; n.ser = bits[i][0]; n.bsy = 1;
    end else if (!cur[i].bsy && en && mq[i].size() != 0) begin
      cap[i] = mq[i].pop_front();
      n.dq = 1; n.bsy = 1;
    end
    cur[i] = n;
  endtask

  task automatic enq(input int i, input logic [7:0] b);
    mq[i].push_back(b);
    eq[i].push_back(b);
    len_q[i] = 8'(eq[i].size());
  endtask

  task automatic cycle(input bit en, input bit rdy);
    enable_in = en;
    ready_in  = rdy;
    if (bv[0] && rdy) begin col0 = {col0[30:0], so[0]}; n0++; end
    if (bv[1] && rdy) begin col1 = {col1[30:0], so[1]}; n1++; end
    @(negedge clk_10KHz);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      model_step(i, en, rdy);
      chk($sformatf("dequeue_out[%0d]", i), 32'(dq[i]),  32'(cur[i].dq));
      chk($sformatf("bit_valid[%0d]", i),   32'(bv[i]),  32'(cur[i].bv));
      chk($sformatf("serial_out[%0d]", i),  32'(so[i]),  32'(cur[i].ser));
      chk($sformatf("byte_done[%0d]", i),   32'(bd[i]),  32'(cur[i].bd));
      chk($sformatf("busy[%0d]", i),        32'(bsy[i]), 32'(cur[i].bsy));
      chk($sformatf("tx_count[%0d]", i),    32'(txc[i]), 32'(tx[i]));
      if (dq[i]) begin
        chk($sformatf("deq_nonempty[%0d]", i), 32'(eq[i].size() != 0), 32'd1);
        if (eq[i].size() != 0) dat_q[i] = eq[i].pop_front();
        len_q[i] = 8'(eq[i].size());
      end
    end
    if (dq[0]) dq_times.push_back(cyc);
    if (bd[0]) bd_times.push_back(cyc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("reset_outputs", 32'({dq, bv, so, bd, bsy}), 32'd0);
    chk("reset_tx0", 32'(txc[0]), 32'd0);
    chk("reset_tx1", 32'(txc[1]), 32'd0);
    for (int i = 0; i < 2; i++) begin
      cur[i] = '0;
      bits[i].delete();
      tx[i] = 0;
    end
    @(negedge clk_10KHz);
    reset = 1'b0;
  endtask

  initial begin
    len_q[0] = '0; len_q[1] = '0;
    dat_q[0] = '0; dat_q[1] = '0;
    #2;
    do_reset();

    // single byte 0xA5, both configurations
    col0 = '0; n0 = 0; col1 = '0; n1 = 0; dq_times.delete();
    enq(0, 8'hA5); enq(1, 8'hA5);
    repeat (40) cycle(1'b1, 1'b1);
`ifdef FILA_SERIALIZER_PARITY_EN
    chk("a5_bits", col0, {23'd0, 8'hA5, 1'b0});
`else
    chk("a5_bits", col0, {24'd0, 8'hA5});
`endif
    chk("a5_nbits", 32'(n0), 32'(NB));
    chk("a5_dequeues", 32'(dq_times.size()), 32'd1);
    chk("a5_tx", 32'(txc[0]), 32'd1);
    chk("a5_len", 32'(len_q[0]), 32'd0);

    // 0x0D on the three-cycle LSB-first instance
    col1 = '0; n1 = 0;
    enq(1, 8'h0D);
    repeat (40) cycle(1'b1, 1'b1);
`ifdef FILA_SERIALIZER_PARITY_EN
    chk("0d_lsb_bits", col1, {5'd0, 24'hE3F000, 3'b111});
`else
    chk("0d_lsb_bits", col1, {8'd0, 24'hE3F000});
`endif
    chk("0d_tx", 32'(txc[1]), 32'd2);

    // three back-to-back bytes
    col0 = '0; n0 = 0; dq_times.delete();
    enq(0, 8'h01); enq(0, 8'h80); enq(0, 8'hFF);
    repeat (50) cycle(1'b1, 1'b1);
    chk("b2b_dequeues", 32'(dq_times.size()), 32'd3);
    if (dq_times.size() == 3) begin
      chk("b2b_gap1", 32'(dq_times[1] - dq_times[0]), 32'(4 + NB));
      chk("b2b_gap2", 32'(dq_times[2] - dq_times[1]), 32'(4 + NB));
    end
`ifdef FILA_SERIALIZER_PARITY_EN
    chk("b2b_bits", col0, {5'd0, 8'h01, 1'b1, 8'h80, 1'b1, 8'hFF, 1'b0});
`else
    chk("b2b_bits", col0, {8'd0, 24'h0180FF});
`endif
    chk("b2b_tx", 32'(txc[0]), 32'd4);

    // five-cycle stall mid-byte
    col0 = '0; n0 = 0; dq_times.delete(); bd_times.delete();
    enq(0, 8'h3C);
    repeat (6) cycle(1'b1, 1'b1);
    repeat (5) cycle(1'b1, 1'b0);
    repeat (20) cycle(1'b1, 1'b1);
    if (dq_times.size() == 1 && bd_times.size() == 1)
      chk("stall_latency", 32'(bd_times[0] - dq_times[0]), 32'(2 + NB + 5));
    else
      chk("stall_events", 32'({dq_times.size(), bd_times.size()}), 32'({1, 1}));
    chk("stall_bits", col0[7:0], 32'(NB == 8 ? 8'h3C : 8'h78));

    // reset while shifting
    enq(0, 8'h5A);
    repeat (7) cycle(1'b1, 1'b1);
    do_reset();
    enq(0, 8'h5A);
    repeat (20) cycle(1'b1, 1'b1);
    chk("post_reset_tx", 32'(txc[0]), 32'd1);

`ifdef FILA_SERIALIZER_PARITY_EN
    col0 = '0; n0 = 0;
    enq(0, 8'h07); enq(0, 8'h03);
    repeat (30) cycle(1'b1, 1'b1);
    chk("parity_bits", col0, {14'd0, 8'h07, 1'b1, 8'h03, 1'b0});
`endif

    // randomized traffic, enable and backpressure
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++)
        if (eq[i].size() < 8 && $urandom_range(0, 3) == 0) enq(i, 8'($urandom));
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7);
    end

    // enable off: in-flight bytes must finish and no new dequeue appears
    begin
      int guard;
      guard = 0;
      while ((bsy != 2'b00) && guard < 200) begin
        cycle(1'b0, 1'b1);
        guard++;
      end
      chk("drain_idle", 32'(bsy), 32'd0);
      repeat (10) cycle(1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fila_serializer.md
Name: fila_serializer

Overview:
- Consumer at the read end of the 8-entry byte queue.
- Watches the queue length, issues single-cycle dequeue pulses, and captures the popped byte.
- Shifts each byte out bit-serially to a downstream sink, with ready backpressure and per-bit valid strobes.
- Sits between the queue and the output/display path; everything runs on clk_10KHz.

Parameters:
- DATA_W, 8: byte width; must match the queue width.
- BIT_CYCLES, 1: clock cycles each bit is held on serial_out (≥1).
- MSB_FIRST, 1: 1 sends bit DATA_W-1 first; 0 sends bit 0 first.

Ports:
- clk_10KHz  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- enable_in  input  1  allows new dequeues; a byte already in flight always completes.
- len_in  input  8  queue length (from queue len_out).
- data_in  input  DATA_W  queue head byte (from queue data_out).
- dequeue_out  output  1  dequeue pulse to queue dequeue_in.
- ready_in  input  1  downstream can accept the current bit.
- serial_out  output  1  current serial bit.
- bit_valid  output  1  high while serial_out holds a valid bit.
- byte_done  output  1  one-cycle pulse after the last bit of a byte is accepted.
- busy  output  1  high in every state except IDLE.
- tx_count  output  8  bytes sent since reset; wraps 255→0.

Behaviour:
- Reset (async): state=IDLE; dequeue_out, serial_out, bit_valid, byte_done, busy all 0; tx_count=0; shift register, bit index and cycle counter cleared.
- All outputs are registered.
- FSM states: IDLE, REQ, WAIT, SHIFT, DONE.
- IDLE → REQ when enable_in=1 and len_in≠0. Otherwise stay in IDLE.
- REQ lasts exactly 1 cycle with dequeue_out=1.
  - The queue latches its head into data_in on the edge that ends REQ.
  - dequeue_out must never be high for two consecutive cycles.
- WAIT lasts exactly 1 cycle with dequeue_out=0.
  - On its ending edge, the block captures data_in into the shift register.
  - On the same edge the queue decrements its length, so len_in is accurate on return to IDLE.
  - Bit index and cycle counter are set to 0; next state is SHIFT.
- SHIFT: bit_valid=1; serial_out = current bit in MSB_FIRST order.
  - The cycle counter advances only when ready_in=1.
  - A bit is accepted when the counter reaches BIT_CYCLES-1 with ready_in=1. The bit index then advances and the counter clears.
  - While ready_in=0, the counter and bit hold; serial_out stays stable.
  - After bit DATA_W-1 (or the parity bit, see Optional Feature) is accepted, go to DONE.
- DONE lasts 1 cycle: byte_done=1, bit_valid=0, tx_count+1. Then return to IDLE.
- Back-to-back: if len_in≠0 in IDLE, the next REQ follows. Minimum per-byte cost = 4 + DATA_W*BIT_CYCLES cycles.
- enable_in deasserted during REQ/WAIT/SHIFT: the byte completes and no further dequeue is issued.
- len_in=0 in IDLE: no dequeue_out, ever. Dequeue against an empty queue is forbidden.
- len_in changing during SHIFT (enqueues) is ignored until IDLE.
- Reset mid-byte: the byte is abandoned; no byte_done; tx_count=0.
- serial_out=0 whenever bit_valid=0.

Optional Feature:
- Macro: FILA_SERIALIZER_PARITY_EN.
- Defined: after the data bits, one extra SHIFT bit carrying even parity (XOR of the captured byte) is sent under the same ready/BIT_CYCLES rules. byte_done follows acceptance of the parity bit.
- Undefined: no parity bit; DONE follows the last data bit. No parity logic is synthesized.

Decomposition:
- Package fila_serializer_pkg:
  - state enum type ser_state_t {IDLE, REQ, WAIT, SHIFT, DONE};
  - localparam QUEUE_DEPTH=8;
  - localparam LEN_W=8.
- One sub-module, ser_bit_timer: counts BIT_CYCLES with a ready gate and emits a bit_accept pulse. It is reused for the parity bit.

Test Plan:
- Queue holds 0xA5, len_in=1, enable_in=1, ready_in=1, BIT_CYCLES=1, MSB_FIRST=1 → dequeue_out high exactly 1 cycle; serial_out sequence 1,0,1,0,0,1,0,1; byte_done 1 cycle later; tx_count=1; returns to IDLE with len_in=0 and no further dequeue.
- Three bytes 0x01,0x80,0xFF back-to-back, ready_in=1 → bytes in queue order; exactly 3 dequeue pulses, each 12 cycles apart; tx_count=3.
- ready_in=0 for 5 cycles mid-byte (after bit 3) → serial_out and bit index frozen; bit_valid stays 1; remaining bits correct after release; total latency +5 cycles.
- BIT_CYCLES=3, MSB_FIRST=0, byte 0x0D → each bit held 3 cycles, LSB first: 1,0,1,1,0,0,0,0.
- Reset asserted during SHIFT of bit 4 → all outputs 0 immediately, tx_count=0, no byte_done; normal operation resumes after release.
- With FILA_SERIALIZER_PARITY_EN, byte 0x07 → 8 data bits then parity bit 1 (three ones → 1); byte 0x03 → parity 0.
